// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR scheduler.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Wide enough for NUM_COEFF full-scale products without overflow.
  function automatic int acc_width(input int size, input int ncoeff);
    return 2 * size + $clog2(ncoeff);
  endfunction

  function automatic int default_coeff(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered unsigned multiply-accumulate; clr wins over accumulate when enabled.
module fir_mac #(
  parameter int SIZE  = 8,
  parameter int ACC_W = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] acc_lo
);

  logic [2*SIZE-1:0] prod;
  logic [ACC_W-1:0]  acc_reg;

  assign prod   = a * b;
  assign acc_lo = acc_reg[SIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (en) begin
      if (clr) acc_reg <= '0;
      else     acc_reg <= acc_reg + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_mac_sched.sv
// FIR scheduler: one shared MAC walks all taps per sample, results leave over valid/ready.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int NUM_COEFF = 4,
  parameter int SIZE      = 8,
  parameter int ACC_W     = acc_width(SIZE, NUM_COEFF)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic [SIZE-1:0]              in_data,
  output logic                         in_ready,
  input  logic                         coeff_we,
  input  logic [$clog2(NUM_COEFF)-1:0] coeff_addr,
  input  logic [SIZE-1:0]              coeff_data,
  output logic                         out_valid,
  output logic [SIZE-1:0]              out_data,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int KW = $clog2(NUM_COEFF);
  localparam logic [KW-1:0] LAST_K  = KW'(NUM_COEFF - 1);
  localparam logic [KW:0]   NUM_L   = (KW + 1)'(NUM_COEFF);

  state_t          state_reg;
  logic [KW-1:0]   k_reg;
  logic            out_valid_reg;
  logic            busy_reg;
  logic [SIZE-1:0] hist_reg  [NUM_COEFF];
  logic [SIZE-1:0] coeff_reg [NUM_COEFF];

  logic            accept;
  logic            coeff_wr;
  logic            mac_en;
  logic [SIZE-1:0] x_sel;
  logic [SIZE-1:0] c_sel;

  assign in_ready  = rst_n & en & (state_reg == IDLE);
  assign accept    = in_valid & in_ready;
  // Out-of-range addresses are dropped so a wide address bus cannot alias taps.
  assign coeff_wr  = coeff_we & en & (state_reg == IDLE) & ({1'b0, coeff_addr} < NUM_L);
  assign mac_en    = en & (accept | (state_reg == MAC));
  assign x_sel     = hist_reg[k_reg];
  assign c_sel     = coeff_reg[k_reg];
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEFF; i++) hist_reg[i] <= '0;
    end else if (accept) begin
      hist_reg[0] <= in_data;
      for (int i = 1; i < NUM_COEFF; i++) hist_reg[i] <= hist_reg[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEFF; i++) coeff_reg[i] <= SIZE'(default_coeff(i));
    end else if (coeff_wr) begin
      for (int i = 0; i < NUM_COEFF; i++)
        if (coeff_addr == KW'(i)) coeff_reg[i] <= coeff_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (en) begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= MAC;
            k_reg     <= '0;
            busy_reg  <= 1'b1;
          end
        end
        MAC: begin
          if (k_reg == LAST_K) begin
            state_reg     <= OUT;
            k_reg         <= '0;
            out_valid_reg <= 1'b1;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  // The accept edge clears the accumulator; the following NUM_COEFF edges add one tap each.
  fir_mac #(
    .SIZE  (SIZE),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mac_en),
    .clr    (accept),
    .a      (x_sel),
    .b      (c_sel),
    .acc_lo (out_data)
  );

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched with hand-computed expected outputs.
module tb_fir_mac_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       coeff_we = 1'b0;
  logic [1:0] coeff_addr = '0;
  logic [7:0] coeff_data = '0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  fir_mac_sched #(
    .NUM_COEFF (4),
    .SIZE      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    acc_cyc  = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    $display("send x=%0d cycle=%0d", d, acc_cyc);
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic get(input string tag, input logic [7:0] exp, input int lat);
    wait_valid(tag);
    check(tag, out_data, exp);
    if (lat > 0) check({tag, "_lat"}, cyc - acc_cyc, lat);
    $display("recv %s y=%0d latency=%0d", tag, out_data, cyc - acc_cyc);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] imp_out  [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
  logic [7:0] imp_in   [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] step_out [5] = '{8'd10, 8'd30, 8'd60, 8'd100, 8'd100};
  logic [7:0] wrap_out [4] = '{8'd89, 8'd67, 8'd34, 8'd246};

  initial begin
    en = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);

    // Impulse through default coefficients 1,2,3,4.
    for (int i = 0; i < 5; i++) begin
      send(imp_in[i]);
      get($sformatf("imp%0d", i), imp_out[i], 5);
    end

    for (int i = 0; i < 5; i++) begin
      send(8'd10);
      get($sformatf("step%0d", i), step_out[i], 5);
    end

    for (int i = 0; i < 4; i++) begin
      send(8'd255);
      get($sformatf("wrap%0d", i), wrap_out[i], 5);
    end

    // Backpressure: history 1,255,255,255 -> 2296 mod 256 = 248.
    send(8'd1);
    wait_valid("bp");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid%0d", i), out_valid, 1);
      check($sformatf("bp_data%0d", i), out_data, 248);
      check($sformatf("bp_in_ready%0d", i), in_ready, 0);
      check($sformatf("bp_busy%0d", i), busy, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_valid", out_valid, 0);
    check("bp_after_busy", busy, 0);
    check("bp_after_in_ready", in_ready, 1);
    $display("recv bp y=248 released after 3 stall cycles");

    // Coefficient writes from a clean state.
    do_reset();
    @(negedge clk);
    coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = 8'd5;
    @(negedge clk);
    coeff_we = 1'b0;
    send(8'd2);
    get("cw_c0", 8'd10, 5);

    // Write c[1]=7 on the same edge as an accept: history 0,2,0,0 -> 14.
    @(negedge clk);
    coeff_we = 1'b1; coeff_addr = 2'd1; coeff_data = 8'd7;
    in_data = 8'd0; in_valid = 1'b1; acc_cyc = cyc;
    @(negedge clk);
    coeff_we = 1'b0; in_valid = 1'b0;
    get("cw_same", 8'd14, 5);

    // Write during MAC must be ignored: history 0,0,2,0 -> 6.
    send(8'd0);
    coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = 8'd9;
    @(negedge clk);
    @(negedge clk);
    coeff_we = 1'b0;
    get("cw_mac", 8'd6, 5);
    send(8'd1);
    get("cw_readback", 8'd13, 5);

    // Reset in the middle of MAC.
    send(8'd3);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(imp_in[i]);
      get($sformatf("post_rst%0d", i), imp_out[i], 5);
    end

    // Enable low for two cycles mid-MAC: history 7,0,0,0 -> 7, two cycles later.
    send(8'd7);
    en = 1'b0;
    #1 check("en_low_in_ready", in_ready, 0);
    @(negedge clk);
    check("en_low_busy", busy, 1);
    check("en_low_valid", out_valid, 0);
    @(negedge clk);
    en = 1'b1;
    wait_valid("en");
    check("en_data", out_data, 7);
    check("en_lat", cyc - acc_cyc, 7);
    en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("en_hold_valid", out_valid, 1);
    check("en_hold_in_ready", in_ready, 0);
    en = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("en_release_valid", out_valid, 0);
    $display("recv en y=7 latency=7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
